// File: rtl/truthtable_scanner.sv
// Exhaustive scan harness for a 3-input/1-output truthtable stage.
// Walks {x3,x2,x1} through 0..7, captures f into an 8-bit table and compares it against EXPECTED.
module truthtable_scanner #(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] EXPECTED      = 8'h4B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       x3,
    output logic       x2,
    output logic       x1,
    input  logic       f,
    output logic       done,
    output logic       result_valid,
    output logic [7:0] table_out,
    output logic [7:0] mismatch_mask,
    output logic       match
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (settle_cnt >= SETTLE_MAX) begin
                    sample = 1'b1;
                    if (idx == 3'd7) begin
                        next_state = FINISH;
                    end
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // x is driven straight from the registered index, so it never changes inside a window.
    assign {x3, x2, x1} = idx;
    assign busy         = (state == SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= 3'd0;
            settle_cnt    <= 4'd0;
            done          <= 1'b0;
            result_valid  <= 1'b0;
            table_out     <= 8'd0;
            mismatch_mask <= 8'd0;
            match         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                idx           <= 3'd0;
                settle_cnt    <= 4'd0;
                result_valid  <= 1'b0;
                table_out     <= 8'd0;
                mismatch_mask <= 8'd0;
                match         <= 1'b0;
            end else if (state == SCAN) begin
                if (sample) begin
                    // idx wraps 7 -> 0 on the last sample, returning x to 000 for FINISH/IDLE.
                    table_out[idx] <= f;
                    settle_cnt     <= 4'd0;
                    idx            <= idx + 3'd1;
                end else begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
            end else if (state == FINISH) begin
                done          <= 1'b1;
                result_valid  <= 1'b1;
                mismatch_mask <= table_out ^ EXPECTED;
                match         <= (table_out == EXPECTED);
            end
        end
    end

endmodule

// File: tb/tb_truthtable_scanner.sv
// Directed bench for truthtable_scanner: one DUT with default settling, one with SETTLE_CYCLES=0.
module tb_truthtable_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start0;

    logic       busy, x3, x2, x1, f, done, result_valid, match;
    logic [7:0] table_out, mismatch_mask;
    logic       busy0, x3_0, x2_0, x1_0, f0, done0, result_valid0, match0;
    logic [7:0] table_out0, mismatch_mask0;

    logic [7:0] golden    = 8'h4B;
    logic       force_one = 1'b0;

    int checks = 0;
    int passed = 0;

    logic [2:0] xtr  [0:63];
    logic [2:0] x0tr [0:63];
    logic       bsytr[0:63];
    logic       rvtr [0:63];
    int         dl[$];
    int         dl0[$];
    logic       m0l[$];
    logic [7:0] t0l[$];

    always #5 clk = ~clk;

    // Reference truthtable feeding each DUT.
    always_comb f  = force_one ? 1'b1 : golden[{x3, x2, x1}];
    always_comb f0 = golden[{x3_0, x2_0, x1_0}];

    truthtable_scanner #(.SETTLE_CYCLES(1), .EXPECTED(8'h4B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .x3(x3), .x2(x2), .x1(x1), .f(f), .done(done),
        .result_valid(result_valid), .table_out(table_out),
        .mismatch_mask(mismatch_mask), .match(match)
    );

    truthtable_scanner #(.SETTLE_CYCLES(0), .EXPECTED(8'h4B)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
        .x3(x3_0), .x2(x2_0), .x1(x1_0), .f(f0), .done(done0),
        .result_valid(result_valid0), .table_out(table_out0),
        .mismatch_mask(mismatch_mask0), .match(match0)
    );

    // Raise the selected starts for edge T0, then run ncyc edges recording outputs.
    task automatic launch_observe(input bit s, input bit s0, input int ncyc,
                                  input logic [63:0] smask, input logic [63:0] s0mask,
                                  input logic [63:0] rmask);
        dl.delete(); dl0.delete(); m0l.delete(); t0l.delete();
        start  = s;
        start0 = s0;
        @(posedge clk);
        #1;
        for (int n = 1; n <= ncyc; n++) begin
            start  = smask[n];
            start0 = s0mask[n];
            rst_n  = !rmask[n];
            @(posedge clk);
            #1;
            xtr[n]   = {x3, x2, x1};
            x0tr[n]  = {x3_0, x2_0, x1_0};
            bsytr[n] = busy;
            rvtr[n]  = result_valid;
            if (done) dl.push_back(n);
            if (done0) begin
                dl0.push_back(n);
                m0l.push_back(match0);
                t0l.push_back(table_out0);
            end
        end
        start  = 1'b0;
        start0 = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        logic any_busy, any_done, any_rv, any_x;
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
        #12;
        checks++; if ({busy, done, result_valid, match} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, result_valid, match}); else passed++;
        checks++; if ({x3, x2, x1} !== 3'b000) $display("FAIL reset_x: got %b expected 000", {x3, x2, x1}); else passed++;
        checks++; if ({table_out, mismatch_mask} !== 16'h0) $display("FAIL reset_tables: got %h expected 0000", {table_out, mismatch_mask}); else passed++;
        checks++; if ({busy0, done0, result_valid0, table_out0} !== 11'h0) $display("FAIL reset_dut0: got %h expected 0", {busy0, done0, result_valid0, table_out0}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        any_busy = 1'b0; any_done = 1'b0; any_rv = 1'b0; any_x = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            any_busy |= busy;
            any_done |= done;
            any_rv   |= result_valid;
            any_x    |= x3 | x2 | x1;
        end
        checks++; if (any_busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", any_busy); else passed++;
        checks++; if (any_done !== 1'b0) $display("FAIL idle_done: got %b expected 0", any_done); else passed++;
        checks++; if (any_rv !== 1'b0) $display("FAIL idle_result_valid: got %b expected 0", any_rv); else passed++;
        checks++; if (any_x !== 1'b0) $display("FAIL idle_x: got %b expected 0", any_x); else passed++;
        checks++; if (table_out !== 8'h00) $display("FAIL idle_table: got %h expected 00", table_out); else passed++;
    endtask

    task automatic test_golden();
        int first;
        launch_observe(1'b1, 1'b0, 20, 64'd0, 64'd0, 64'd0);
        first = (dl.size() > 0) ? dl[0] : -1;
        checks++; if (dl.size() !== 1) $display("FAIL golden_done_count: got %0d expected 1", dl.size()); else passed++;
        checks++; if (first !== 17) $display("FAIL golden_done_at: got %0d expected 17", first); else passed++;
        for (int n = 1; n <= 15; n++) begin
            checks++; if (xtr[n] !== 3'(n / 2)) $display("FAIL golden_x_step%0d: got %0d expected %0d", n, xtr[n], n / 2); else passed++;
        end
        checks++; if (xtr[17] !== 3'd0) $display("FAIL golden_x_after: got %0d expected 0", xtr[17]); else passed++;
        checks++; if (bsytr[1] !== 1'b1) $display("FAIL golden_busy_scan: got %b expected 1", bsytr[1]); else passed++;
        checks++; if (bsytr[16] !== 1'b0) $display("FAIL golden_busy_finish: got %b expected 0", bsytr[16]); else passed++;
        checks++; if (table_out !== 8'h4B) $display("FAIL golden_table: got %h expected 4b", table_out); else passed++;
        checks++; if (mismatch_mask !== 8'h00) $display("FAIL golden_mask: got %h expected 00", mismatch_mask); else passed++;
        checks++; if ({match, result_valid} !== 2'b11) $display("FAIL golden_match_valid: got %b expected 11", {match, result_valid}); else passed++;
    endtask

    task automatic test_force_one();
        int first;
        force_one = 1'b1;
        launch_observe(1'b1, 1'b0, 20, 64'd0, 64'd0, 64'd0);
        force_one = 1'b0;
        first = (dl.size() > 0) ? dl[0] : -1;
        checks++; if (rvtr[1] !== 1'b0) $display("FAIL force_valid_cleared: got %b expected 0", rvtr[1]); else passed++;
        checks++; if (first !== 17) $display("FAIL force_done_at: got %0d expected 17", first); else passed++;
        checks++; if (table_out !== 8'hFF) $display("FAIL force_table: got %h expected ff", table_out); else passed++;
        checks++; if (mismatch_mask !== 8'hB4) $display("FAIL force_mask: got %h expected b4", mismatch_mask); else passed++;
        checks++; if ({match, result_valid} !== 2'b01) $display("FAIL force_match_valid: got %b expected 01", {match, result_valid}); else passed++;
    endtask

    task automatic test_restart_ignored();
        int first;
        logic [63:0] m;
        m = 64'd0;
        m[5] = 1'b1;
        m[10] = 1'b1;
        launch_observe(1'b1, 1'b0, 30, m, 64'd0, 64'd0);
        first = (dl.size() > 0) ? dl[0] : -1;
        checks++; if (dl.size() !== 1) $display("FAIL restart_done_count: got %0d expected 1", dl.size()); else passed++;
        checks++; if (first !== 17) $display("FAIL restart_done_at: got %0d expected 17", first); else passed++;
        checks++; if ({table_out, mismatch_mask, match} !== {8'h4B, 8'h00, 1'b1}) $display("FAIL restart_result: got %h/%h/%b expected 4b/00/1", table_out, mismatch_mask, match); else passed++;
    endtask

    task automatic test_abort();
        int first;
        logic [63:0] r;
        r = 64'd0;
        r[9] = 1'b1;
        launch_observe(1'b1, 1'b0, 25, 64'd0, 64'd0, r);
        checks++; if (dl.size() !== 0) $display("FAIL abort_done_count: got %0d expected 0", dl.size()); else passed++;
        checks++; if ({busy, result_valid, table_out} !== 10'h0) $display("FAIL abort_cleared: got %h expected 0", {busy, result_valid, table_out}); else passed++;
        launch_observe(1'b1, 1'b0, 20, 64'd0, 64'd0, 64'd0);
        first = (dl.size() > 0) ? dl[0] : -1;
        checks++; if (first !== 17) $display("FAIL abort_rescan_done_at: got %0d expected 17", first); else passed++;
        checks++; if ({table_out, match} !== {8'h4B, 1'b1}) $display("FAIL abort_rescan_result: got %h/%b expected 4b/1", table_out, match); else passed++;
    endtask

    task automatic test_back_to_back();
        int exp_at[3];
        exp_at = '{9, 19, 29};
        launch_observe(1'b0, 1'b1, 35, 64'd0, {64{1'b1}}, 64'd0);
        checks++; if (dl0.size() !== 3) $display("FAIL b2b_done_count: got %0d expected 3", dl0.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < dl0.size()) begin
                checks++; if (dl0[i] !== exp_at[i]) $display("FAIL b2b_done_at%0d: got %0d expected %0d", i, dl0[i], exp_at[i]); else passed++;
                checks++; if ({m0l[i], t0l[i]} !== {1'b1, 8'h4B}) $display("FAIL b2b_match%0d: got %b/%h expected 1/4b", i, m0l[i], t0l[i]); else passed++;
            end
        end
        checks++; if (x0tr[3] !== 3'd3) $display("FAIL b2b_x_step3: got %0d expected 3", x0tr[3]); else passed++;
        checks++; if (x0tr[8] !== 3'd0) $display("FAIL b2b_x_finish: got %0d expected 0", x0tr[8]); else passed++;
    endtask

    initial begin
        test_reset();
        test_golden();
        test_force_one();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
